calc_sequencer: RTL and testbench

- Front-end controller for the instruction-cache calculator (mode/opCode/value/clk/reset interface; 32-entry cache; opCodes 011/111 invalid).
- Arbitrates instruction loads from two requesters round-robin, filters invalid opcodes, and tracks cache occupancy.
- Runs bounded execute bursts (mode=1), aborting on calculator overflow. Issues clear pulses to the calculator's active-high reset.

---
 rtl/calc_sequencer.sv | 142 ++++++++++++++
 tb/tb_calc_sequencer.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/calc_sequencer.sv
// Front-end controller for the instruction-cache calculator: round-robin load
// arbitration, invalid-op filtering, occupancy tracking, bounded execute bursts.
module calc_sequencer #(
  parameter int CACHE_DEPTH = 32,
  parameter int STEP_W      = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic [2:0]        req0_op,
  input  logic [3:0]        req0_val,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [2:0]        req1_op,
  input  logic [3:0]        req1_val,
  output logic              req1_ready,
  input  logic              run_start,
  input  logic [STEP_W-1:0] run_steps,
  input  logic              clear,
  input  logic              calc_overflow,
  output logic              calc_mode,
  output logic [2:0]        calc_opCode,
  output logic [3:0]        calc_value,
  output logic              calc_reset,
  output logic [5:0]        loaded_count,
  output logic              cache_full,
  output logic              rejected,
  output logic              busy,
  output logic              done,
  output logic              ovf_abort
);

  localparam logic [2:0] NOP_OP = 3'b011;

  typedef enum logic [1:0] {IDLE, CLR, RUN, DRAIN} state_t;

  state_t            state_reg;
  logic              last_grant_reg;
  logic [STEP_W-1:0] steps_left_reg;
  logic              first_step_reg;

  logic       idle;
  logic       gnt0, gnt1;
  logic       inv0, inv1;
  logic       xfer;
  logic [2:0] xfer_op;
  logic [3:0] xfer_val;

  assign idle       = (state_reg == IDLE);
  assign busy       = !idle;
  assign cache_full = (loaded_count == 6'(CACHE_DEPTH));

  // last_grant_reg==1 means req1 won last, so req0 takes the next tie.
  assign gnt0 = req0_valid & (!req1_valid | last_grant_reg);
  assign gnt1 = req1_valid & (!req0_valid | !last_grant_reg);
  assign inv0 = (req0_op[1:0] == 2'b11);
  assign inv1 = (req1_op[1:0] == 2'b11);

  assign req0_ready = idle & !clear & !run_start & gnt0 & (!cache_full | inv0);
  assign req1_ready = idle & !clear & !run_start & gnt1 & (!cache_full | inv1);

  assign xfer     = req0_ready | req1_ready;
  assign xfer_op  = req1_ready ? req1_op  : req0_op;
  assign xfer_val = req1_ready ? req1_val : req0_val;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg      <= IDLE;
      last_grant_reg <= 1'b1;
      steps_left_reg <= '0;
      first_step_reg <= 1'b0;
      calc_mode      <= 1'b0;
      calc_opCode    <= NOP_OP;
      calc_value     <= 4'd0;
      calc_reset     <= 1'b0;
      loaded_count   <= 6'd0;
      rejected       <= 1'b0;
      done           <= 1'b0;
      ovf_abort      <= 1'b0;
    end else begin
      calc_mode   <= 1'b0;
      calc_opCode <= NOP_OP;
      calc_value  <= 4'd0;
      calc_reset  <= 1'b0;
      rejected    <= 1'b0;
      done        <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (clear) begin
            state_reg  <= CLR;
            calc_reset <= 1'b1;
          end else if (run_start) begin
            ovf_abort <= 1'b0;
            if (run_steps == '0 || loaded_count == 6'd0) begin
              done <= 1'b1;
            end else begin
              state_reg      <= RUN;
              calc_mode      <= 1'b1;
              steps_left_reg <= run_steps - 1'b1;
              first_step_reg <= 1'b1;
            end
          end else if (xfer) begin
            last_grant_reg <= req1_ready;
            if (xfer_op[1:0] == 2'b11) begin
              rejected <= 1'b1;
            end else begin
              calc_opCode  <= xfer_op;
              calc_value   <= xfer_val;
              loaded_count <= loaded_count + 6'd1;
            end
          end
        end
        CLR: begin
          loaded_count <= 6'd0;
          ovf_abort    <= 1'b0;
          state_reg    <= IDLE;
        end
        RUN: begin
          first_step_reg <= 1'b0;
          // Overflow seen in the first RUN cycle predates this burst.
          if (!first_step_reg && calc_overflow) begin
            ovf_abort <= 1'b1;
            done      <= 1'b1;
            state_reg <= IDLE;
          end else if (steps_left_reg == '0) begin
            state_reg <= DRAIN;
          end else begin
            calc_mode      <= 1'b1;
            steps_left_reg <= steps_left_reg - 1'b1;
          end
        end
        DRAIN: begin
          if (calc_overflow) ovf_abort <= 1'b1;
          done      <= 1'b1;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_calc_sequencer.sv
// Directed bench for calc_sequencer: a vector table stepped one clock at a time,
// plus hand-written sequences for cache fill and reset during a burst.
module tb_calc_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       req0_valid, req1_valid, req0_ready, req1_ready;
  logic [2:0] req0_op, req1_op;
  logic [3:0] req0_val, req1_val;
  logic       run_start, clear, calc_overflow;
  logic [7:0] run_steps;
  logic       calc_mode, calc_reset, cache_full, rejected, busy, done, ovf_abort;
  logic [2:0] calc_opCode;
  logic [3:0] calc_value;
  logic [5:0] loaded_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  calc_sequencer #(.CACHE_DEPTH(32), .STEP_W(8)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_op(req0_op), .req0_val(req0_val), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_op(req1_op), .req1_val(req1_val), .req1_ready(req1_ready),
    .run_start(run_start), .run_steps(run_steps), .clear(clear),
    .calc_overflow(calc_overflow),
    .calc_mode(calc_mode), .calc_opCode(calc_opCode), .calc_value(calc_value),
    .calc_reset(calc_reset), .loaded_count(loaded_count), .cache_full(cache_full),
    .rejected(rejected), .busy(busy), .done(done), .ovf_abort(ovf_abort)
  );

  typedef struct {
    logic       r0v; logic [2:0] r0op; logic [3:0] r0val;
    logic       r1v; logic [2:0] r1op; logic [3:0] r1val;
    logic       rs;  logic [7:0] steps; logic clr; logic ovf;
    logic       e_rdy0, e_rdy1;
    logic       e_mode; logic [2:0] e_op; logic [3:0] e_val; logic e_creset;
    logic [5:0] e_cnt; logic e_rej, e_busy, e_done, e_abort;
  } vec_t;

  vec_t vecs[23];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    req0_valid = 0; req0_op = 3'b011; req0_val = 0;
    req1_valid = 0; req1_op = 3'b011; req1_val = 0;
    run_start = 0; run_steps = 0; clear = 0; calc_overflow = 0;
  endtask

  task automatic apply(input int idx, input vec_t v);
    @(negedge clk);
    req0_valid = v.r0v; req0_op = v.r0op; req0_val = v.r0val;
    req1_valid = v.r1v; req1_op = v.r1op; req1_val = v.r1val;
    run_start = v.rs; run_steps = v.steps; clear = v.clr; calc_overflow = v.ovf;
    #1;
    chk($sformatf("v%0d req0_ready", idx), req0_ready, v.e_rdy0);
    chk($sformatf("v%0d req1_ready", idx), req1_ready, v.e_rdy1);
    @(posedge clk); #1;
    chk($sformatf("v%0d calc_mode", idx), calc_mode, v.e_mode);
    chk($sformatf("v%0d calc_opCode", idx), calc_opCode, v.e_op);
    chk($sformatf("v%0d calc_value", idx), calc_value, v.e_val);
    chk($sformatf("v%0d calc_reset", idx), calc_reset, v.e_creset);
    chk($sformatf("v%0d loaded_count", idx), loaded_count, v.e_cnt);
    chk($sformatf("v%0d rejected", idx), rejected, v.e_rej);
    chk($sformatf("v%0d busy", idx), busy, v.e_busy);
    chk($sformatf("v%0d done", idx), done, v.e_done);
    chk($sformatf("v%0d ovf_abort", idx), ovf_abort, v.e_abort);
    $display("vec %0d: rdy=%b%b mode=%b op=%b val=%0d cnt=%0d rej=%b busy=%b done=%b abort=%b",
             idx, v.e_rdy0, v.e_rdy1, calc_mode, calc_opCode, calc_value, loaded_count,
             rejected, busy, done, ovf_abort);
  endtask

  initial begin
    bit exp_g;
    //           r0v op    val  r1v op    val  rs steps clr ovf  rdy0 rdy1 mode op    val cr cnt rej busy done abort
    vecs[0]  = '{1, 3'd0, 4'd5, 1, 3'd1, 4'd2, 0, 8'd0,  0,  0,   1,   0,   0, 3'd0, 4'd5, 0, 6'd2-6'd1, 0, 0, 0, 0};
    vecs[1]  = '{1, 3'd0, 4'd5, 1, 3'd1, 4'd2, 0, 8'd0,  0,  0,   0,   1,   0, 3'd1, 4'd2, 0, 6'd2, 0, 0, 0, 0};
    vecs[2]  = '{0, 3'd0, 4'd0, 1, 3'd3, 4'd7, 0, 8'd0,  0,  0,   0,   1,   0, 3'd3, 4'd0, 0, 6'd2, 1, 0, 0, 0};
    vecs[3]  = '{0, 3'd0, 4'd0, 0, 3'd0, 4'd0, 0, 8'd0,  0,  0,   0,   0,   0, 3'd3, 4'd0, 0, 6'd2, 0, 0, 0, 0};
    vecs[4]  = '{0, 3'd0, 4'd0, 0, 3'd0, 4'd0, 1, 8'd4,  0,  0,   0,   0,   1, 3'd3, 4'd0, 0, 6'd2, 0, 1, 0, 0};
    vecs[5]  = '{1, 3'd0, 4'd9, 0, 3'd0, 4'd0, 0, 8'd0,  0,  0,   0,   0,   1, 3'd3, 4'd0, 0, 6'd2, 0, 1, 0, 0};
    vecs[6]  = '{0, 3'd0, 4'd0, 0, 3'd0, 4'd0, 0, 8'd0,  1,  0,   0,   0,   1, 3'd3, 4'd0, 0, 6'd2, 0, 1, 0, 0};
    vecs[7]  = '{0, 3'd0, 4'd0, 0, 3'd0, 4'd0, 1, 8'd9,  0,  0,   0,   0,   1, 3'd3, 4'd0, 0, 6'd2, 0, 1, 0, 0};
    vecs[8]  = '{0, 3'd0, 4'd0, 0, 3'd0, 4'd0, 0, 8'd0,  0,  0,   0,   0,   0, 3'd3, 4'd0, 0, 6'd2, 0, 1, 0, 0};
    vecs[9]  = '{0, 3'd0, 4'd0, 0, 3'd0, 4'd0, 0, 8'd0,  0,  0,   0,   0,   0, 3'd3, 4'd0, 0, 6'd2, 0, 0, 1, 0};
    vecs[10] = '{0, 3'd0, 4'd0, 0, 3'd0, 4'd0, 0, 8'd0,  0,  0,   0,   0,   0, 3'd3, 4'd0, 0, 6'd2, 0, 0, 0, 0};
    vecs[11] = '{0, 3'd0, 4'd0, 0, 3'd0, 4'd0, 1, 8'd10, 0,  0,   0,   0,   1, 3'd3, 4'd0, 0, 6'd2, 0, 1, 0, 0};
    vecs[12] = '{0, 3'd0, 4'd0, 0, 3'd0, 4'd0, 0, 8'd0,  0,  1,   0,   0,   1, 3'd3, 4'd0, 0, 6'd2, 0, 1, 0, 0};
    vecs[13] = '{0, 3'd0, 4'd0, 0, 3'd0, 4'd0, 0, 8'd0,  0,  0,   0,   0,   1, 3'd3, 4'd0, 0, 6'd2, 0, 1, 0, 0};
    vecs[14] = '{0, 3'd0, 4'd0, 0, 3'd0, 4'd0, 0, 8'd0,  0,  1,   0,   0,   0, 3'd3, 4'd0, 0, 6'd2, 0, 0, 1, 1};
    vecs[15] = '{0, 3'd0, 4'd0, 0, 3'd0, 4'd0, 0, 8'd0,  0,  0,   0,   0,   0, 3'd3, 4'd0, 0, 6'd2, 0, 0, 0, 1};
    vecs[16] = '{0, 3'd0, 4'd0, 0, 3'd0, 4'd0, 1, 8'd5,  1,  0,   0,   0,   0, 3'd3, 4'd0, 1, 6'd2, 0, 1, 0, 1};
    vecs[17] = '{0, 3'd0, 4'd0, 0, 3'd0, 4'd0, 0, 8'd0,  0,  0,   0,   0,   0, 3'd3, 4'd0, 0, 6'd0, 0, 0, 0, 0};
    vecs[18] = '{0, 3'd0, 4'd0, 0, 3'd0, 4'd0, 1, 8'd3,  0,  0,   0,   0,   0, 3'd3, 4'd0, 0, 6'd0, 0, 0, 1, 0};
    vecs[19] = '{0, 3'd0, 4'd0, 0, 3'd0, 4'd0, 0, 8'd0,  0,  0,   0,   0,   0, 3'd3, 4'd0, 0, 6'd0, 0, 0, 0, 0};
    vecs[20] = '{0, 3'd0, 4'd0, 1, 3'd0, 4'd3, 0, 8'd0,  0,  0,   0,   1,   0, 3'd0, 4'd3, 0, 6'd1, 0, 0, 0, 0};
    vecs[21] = '{0, 3'd0, 4'd0, 0, 3'd0, 4'd0, 1, 8'd0,  0,  0,   0,   0,   0, 3'd3, 4'd0, 0, 6'd1, 0, 0, 1, 0};
    vecs[22] = '{0, 3'd0, 4'd0, 0, 3'd0, 4'd0, 0, 8'd0,  0,  0,   0,   0,   0, 3'd3, 4'd0, 0, 6'd1, 0, 0, 0, 0};

    idle_inputs();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst calc_mode", calc_mode, 1'b0);
    chk("rst calc_opCode", calc_opCode, 3'b011);
    chk("rst calc_value", calc_value, 4'd0);
    chk("rst calc_reset", calc_reset, 1'b0);
    chk("rst loaded_count", loaded_count, 6'd0);
    chk("rst cache_full", cache_full, 1'b0);
    chk("rst busy", busy, 1'b0);
    chk("rst done", done, 1'b0);
    chk("rst ovf_abort", ovf_abort, 1'b0);
    $display("reset: mode=%b op=%b cnt=%0d busy=%b", calc_mode, calc_opCode, loaded_count, busy);
    reset = 1'b1;

    for (int i = 0; i < 23; i++) apply(i, vecs[i]);

    // Empty the cache, then fill it with both requesters contending.
    @(negedge clk); idle_inputs(); clear = 1;
    @(negedge clk); clear = 0;
    @(negedge clk);
    chk("fill start count", loaded_count, 6'd0);
    exp_g = 1'b0;  // req1 won the last transfer, so req0 takes the first tie
    for (int i = 0; i < 32; i++) begin
      logic [3:0] v0, v1;
      v0 = i[3:0];
      v1 = ~v0;
      req0_valid = 1; req0_op = 3'b000; req0_val = v0;
      req1_valid = 1; req1_op = 3'b010; req1_val = v1;
      #1;
      chk($sformatf("fill%0d req0_ready", i), req0_ready, !exp_g);
      chk($sformatf("fill%0d req1_ready", i), req1_ready, exp_g);
      @(posedge clk); #1;
      chk($sformatf("fill%0d opCode", i), calc_opCode, exp_g ? 3'b010 : 3'b000);
      chk($sformatf("fill%0d value", i), calc_value, exp_g ? v1 : v0);
      chk($sformatf("fill%0d count", i), loaded_count, i + 1);
      chk($sformatf("fill%0d full", i), cache_full, (i == 31));
      $display("fill %0d: grant=%0d op=%b val=%0d cnt=%0d full=%b",
               i, exp_g, calc_opCode, calc_value, loaded_count, cache_full);
      exp_g = !exp_g;
      @(negedge clk);
    end
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("full%0d req0_ready", i), req0_ready, 1'b0);
      chk($sformatf("full%0d req1_ready", i), req1_ready, 1'b0);
      @(negedge clk);
      chk($sformatf("full%0d count", i), loaded_count, 6'd32);
      $display("full hold %0d: cnt=%0d full=%b", i, loaded_count, cache_full);
    end
    req1_valid = 0; req0_op = 3'b111; req0_val = 4'd6;
    #1;
    chk("full invalid req0_ready", req0_ready, 1'b1);
    @(posedge clk); #1;
    chk("full invalid rejected", rejected, 1'b1);
    chk("full invalid opCode", calc_opCode, 3'b011);
    chk("full invalid count", loaded_count, 6'd32);
    $display("full invalid: rej=%b op=%b cnt=%0d", rejected, calc_opCode, loaded_count);

    // Asynchronous reset while a burst is in progress.
    @(negedge clk); idle_inputs(); run_start = 1; run_steps = 8'd20;
    @(negedge clk); run_start = 0;
    repeat (2) @(negedge clk);
    chk("midrun busy", busy, 1'b1);
    chk("midrun mode", calc_mode, 1'b1);
    #2 reset = 1'b0;
    #1;
    chk("async rst busy", busy, 1'b0);
    chk("async rst mode", calc_mode, 1'b0);
    chk("async rst opCode", calc_opCode, 3'b011);
    chk("async rst count", loaded_count, 6'd0);
    chk("async rst calc_reset", calc_reset, 1'b0);
    $display("async reset: busy=%b mode=%b cnt=%0d", busy, calc_mode, loaded_count);
    @(negedge clk); reset = 1'b1;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
